// File: rtl/acc_pkg.sv
// Shared types and lane arithmetic for the psum accumulation buffer.
package acc_pkg;

    localparam int unsigned depth_default = 2048;
    localparam int unsigned aw            = $clog2(depth_default);
    // Lane helpers work on lanes sign-extended to this width (psum_bw <= 32).
    localparam int unsigned lane_max_w    = 32;

    // Bit offset of lane i inside a packed psum vector.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lane_w);
        return lane * lane_w;
    endfunction

    // Add two sign-extended lanes of width w; clamp to the w-bit signed range when sat_en.
    function automatic logic [lane_max_w-1:0] sat_add(
        input logic [lane_max_w-1:0] a,
        input logic [lane_max_w-1:0] b,
        input int unsigned           w,
        input logic                  sat_en
    );
        logic signed [lane_max_w:0] sum;
        logic signed [lane_max_w:0] hi;
        logic signed [lane_max_w:0] lo;
        sum = $signed({a[lane_max_w-1], a}) + $signed({b[lane_max_w-1], b});
        hi  = $signed((33'd1 << (w - 1)) - 33'd1);
        lo  = -hi - 33'sd1;
        if (sat_en && (sum > hi)) return hi[lane_max_w-1:0];
        if (sat_en && (sum < lo)) return lo[lane_max_w-1:0];
        return sum[lane_max_w-1:0];
    endfunction

    // Clamp a negative sign-extended lane to zero.
    function automatic logic [lane_max_w-1:0] relu(input logic [lane_max_w-1:0] x);
        return x[lane_max_w-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/acc_bank_1r1w.sv
// Behavioural 1R1W synchronous bank; read-during-write returns the old word.
module acc_bank_1r1w
    import acc_pkg::*;
#(
    parameter int unsigned width  = 128,
    parameter int unsigned depth  = depth_default,
    parameter int unsigned addr_w = aw
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [addr_w-1:0] rd_addr,
    output logic [width-1:0]  rd_data,
    input  logic              wr_en,
    input  logic [addr_w-1:0] wr_addr,
    input  logic [width-1:0]  wr_data
);

    logic [width-1:0] mem [depth];

    // Storage is never reset; read data holds between reads.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/psum_acc_buffer.sv
// Read-modify-write psum accumulation buffer with forwarding and a drain port.
module psum_acc_buffer
    import acc_pkg::*;
#(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 2048,
    parameter bit          sat     = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$clog2(depth)-1:0]   in_addr,
    input  logic                       in_first,
    input  logic [psum_bw*col-1:0]     in_data,
    input  logic                       out_req,
    input  logic [$clog2(depth)-1:0]   out_addr,
    input  logic                       out_relu,
    input  logic                       out_clr,
    output logic                       out_valid,
    output logic [psum_bw*col-1:0]     out_data,
    output logic                       busy
);

    localparam int unsigned addr_w = $clog2(depth);
    localparam int unsigned vec_w  = psum_bw * col;

    logic              accept;
    logic              rd_en;
    logic [addr_w-1:0] rd_addr;
    logic [vec_w-1:0]  rd_data;
    logic              wr_en;
    logic [addr_w-1:0] wr_addr;
    logic [vec_w-1:0]  wr_data;

    logic              s1_valid;
    logic [addr_w-1:0] s1_addr;
    logic              s1_first;
    logic [vec_w-1:0]  s1_data;

    logic              d1_valid;
    logic [addr_w-1:0] d1_addr;
    logic              d1_relu;
    logic              d1_clr;

    logic              fw_valid;
    logic [addr_w-1:0] fw_addr;
    logic [vec_w-1:0]  fw_data;

    logic [addr_w-1:0] ret_addr;
    logic [vec_w-1:0]  rd_eff;
    logic [vec_w-1:0]  sum_vec;
    logic [vec_w-1:0]  drain_vec;

    assign in_ready = reset & ~out_req;
    assign accept   = in_valid & in_ready;
    assign busy     = s1_valid | d1_valid | out_valid;

    // Read port: drain wins, otherwise the accepted accumulate.
    always_comb begin
        rd_en   = out_req | accept;
        rd_addr = out_req ? out_addr : in_addr;
    end

    // Write port: S1 result, or the clear that follows a clear-on-read drain.
    always_comb begin
        wr_en   = reset & (s1_valid | (d1_valid & d1_clr));
        wr_addr = s1_valid ? s1_addr : d1_addr;
        wr_data = s1_valid ? sum_vec : '0;
    end

    // Returned read data, replaced by the write issued in the same cycle as the read.
    always_comb begin
        ret_addr = d1_valid ? d1_addr : s1_addr;
        rd_eff   = (fw_valid && (fw_addr == ret_addr)) ? fw_data : rd_data;
    end

    // Per-lane accumulate and per-lane drain ReLU.
    always_comb begin
        logic [lane_max_w-1:0] a_lane;
        logic [lane_max_w-1:0] b_lane;
        sum_vec   = '0;
        drain_vec = '0;
        a_lane    = '0;
        b_lane    = '0;
        for (int unsigned i = 0; i < col; i++) begin
            a_lane = lane_max_w'($signed(rd_eff[lane_lsb(i, psum_bw) +: psum_bw]));
            b_lane = lane_max_w'($signed(s1_data[lane_lsb(i, psum_bw) +: psum_bw]));
            sum_vec[lane_lsb(i, psum_bw) +: psum_bw] =
                psum_bw'(s1_first ? b_lane : sat_add(a_lane, b_lane, psum_bw, sat));
            drain_vec[lane_lsb(i, psum_bw) +: psum_bw] =
                psum_bw'(d1_relu ? relu(a_lane) : a_lane);
        end
    end

    // Pipeline valids and the drain output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            d1_valid  <= 1'b0;
            fw_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            s1_valid  <= accept;
            d1_valid  <= out_req;
            fw_valid  <= wr_en;
            out_valid <= d1_valid;
            if (d1_valid) begin
                out_data <= drain_vec;
            end
        end
    end

    // Stage payloads and the forwarding copy of the last write.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_addr  <= in_addr;
            s1_first <= in_first;
            s1_data  <= in_data;
        end
        if (out_req) begin
            d1_addr <= out_addr;
            d1_relu <= out_relu;
            d1_clr  <= out_clr;
        end
        fw_addr <= wr_addr;
        fw_data <= wr_data;
    end

    acc_bank_1r1w #(
        .width  (vec_w),
        .depth  (depth),
        .addr_w (addr_w)
    ) u_bank (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

endmodule

// File: tb/tb_psum_acc_buffer.sv
// Bench for psum_acc_buffer: directed vector table plus random stress vs a reference model.
module tb_psum_acc_buffer;

    localparam int unsigned AW = acc_pkg::aw;
    localparam int unsigned W  = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [AW-1:0] in_addr;
    logic          in_first;
    logic [W-1:0]  in_data;
    logic          out_req;
    logic [AW-1:0] out_addr;
    logic          out_relu;
    logic          out_clr;

    logic          rdy_s, ov_s, busy_s;
    logic [W-1:0]  od_s;
    logic          rdy_w, ov_w, busy_w;
    logic [W-1:0]  od_w;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    psum_acc_buffer #(.col(8), .psum_bw(16), .depth(2048), .sat(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s),
        .in_addr(in_addr), .in_first(in_first), .in_data(in_data),
        .out_req(out_req), .out_addr(out_addr), .out_relu(out_relu), .out_clr(out_clr),
        .out_valid(ov_s), .out_data(od_s), .busy(busy_s)
    );

    psum_acc_buffer #(.col(8), .psum_bw(16), .depth(2048), .sat(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_w),
        .in_addr(in_addr), .in_first(in_first), .in_data(in_data),
        .out_req(out_req), .out_addr(out_addr), .out_relu(out_relu), .out_clr(out_clr),
        .out_valid(ov_w), .out_data(od_w), .busy(busy_w)
    );

    // ---------------- reference model ----------------
    logic [W-1:0] m_s [2048];
    logic [W-1:0] m_w [2048];
    bit           known [2048];
    bit           pend_v = 1'b0;
    logic [AW-1:0] pend_a;
    logic [W-1:0] pend_s, pend_w;
    bit           pipe_v = 1'b0;
    logic [W-1:0] pipe_s, pipe_w;
    bit           now_v = 1'b0;
    logic [W-1:0] now_s, now_w;

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [W-1:0] lanes8(input int l0, input int l1, input int l2, input int l3,
                                            input int l4, input int l5, input int l6, input int l7);
        int l [8];
        logic [W-1:0] r;
        l = '{l0, l1, l2, l3, l4, l5, l6, l7};
        r = '0;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(l[i]);
        return r;
    endfunction

    function automatic logic [W-1:0] rep(input int v);
        return lanes8(v, v, v, v, v, v, v, v);
    endfunction

    // Lane-wise signed add with optional clamping to the 16-bit range.
    function automatic logic [W-1:0] vadd(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        logic [W-1:0] r;
        int x;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            x = int'($signed(a[i*16 +: 16])) + int'($signed(b[i*16 +: 16]));
            if (s && x > 32767) x = 32767;
            if (s && x < -32768) x = -32768;
            r[i*16 +: 16] = 16'(x);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] vrelu(input logic [W-1:0] a);
        logic [W-1:0] r;
        r = a;
        for (int i = 0; i < 8; i++) if (a[i*16 + 15]) r[i*16 +: 16] = 16'd0;
        return r;
    endfunction

    // One clock cycle with the current inputs: check, advance model, check outputs after the edge.
    task automatic cycle();
        bit acc_now, drn_now;
        acc_now = 1'b0;
        drn_now = 1'b0;
        #1;
        chk("in_ready_sat", W'(rdy_s), W'(reset && !out_req));
        chk("in_ready_wrap", W'(rdy_w), W'(reset && !out_req));
        now_v = 1'b0;
        if (!reset) begin
            pend_v = 1'b0;
            pipe_v = 1'b0;
        end else begin
            if (pend_v) begin
                m_s[pend_a]   = pend_s;
                m_w[pend_a]   = pend_w;
                known[pend_a] = 1'b1;
            end
            pend_v = 1'b0;
            now_v = pipe_v; now_s = pipe_s; now_w = pipe_w;
            pipe_v = 1'b0;
            if (out_req) begin
                drn_now = 1'b1;
                pipe_v  = 1'b1;
                pipe_s  = out_relu ? vrelu(m_s[out_addr]) : m_s[out_addr];
                pipe_w  = out_relu ? vrelu(m_w[out_addr]) : m_w[out_addr];
                if (out_clr) begin
                    pend_v = 1'b1; pend_a = out_addr; pend_s = '0; pend_w = '0;
                end
            end else if (in_valid) begin
                acc_now = 1'b1;
                pend_v  = 1'b1;
                pend_a  = in_addr;
                pend_s  = in_first ? in_data : vadd(m_s[in_addr], in_data, 1'b1);
                pend_w  = in_first ? in_data : vadd(m_w[in_addr], in_data, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid_sat", W'(ov_s), W'(now_v));
        chk("out_valid_wrap", W'(ov_w), W'(now_v));
        if (now_v) begin
            chk("out_data_sat", od_s, now_s);
            chk("out_data_wrap", od_w, now_w);
        end
        if (!reset) begin
            chk("reset_out_data", od_s | od_w, '0);
        end
        chk("busy_sat", W'(busy_s), W'(acc_now | drn_now | now_v));
        chk("busy_wrap", W'(busy_w), W'(acc_now | drn_now | now_v));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int           rst;
        int           iv;
        int           ia;
        int           fst;
        logic [W-1:0] id;
        int           oq;
        int           oa;
        int           relu;
        int           clr;
        int           chk_en;
        int           ev;
        logic [W-1:0] es;
        logic [W-1:0] ew;
    } vec_t;

    function automatic vec_t mk(input int rst, input int iv, input int ia, input int fst,
                                input logic [W-1:0] id, input int oq, input int oa,
                                input int relu, input int clr);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ia = ia; v.fst = fst; v.id = id;
        v.oq = oq; v.oa = oa; v.relu = relu; v.clr = clr;
        v.chk_en = 0; v.ev = 0; v.es = '0; v.ew = '0;
        return v;
    endfunction

    function automatic vec_t acc_r(input int a, input int fst, input logic [W-1:0] d);
        return mk(1, 1, a, fst, d, 0, 0, 0, 0);
    endfunction

    function automatic vec_t drn_r(input int a, input int relu, input int clr);
        return mk(1, 0, 0, 0, '0, 1, a, relu, clr);
    endfunction

    function automatic vec_t idle_r();
        return mk(1, 0, 0, 0, '0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t ex(input vec_t v, input logic [W-1:0] es, input logic [W-1:0] ew);
        vec_t r;
        r = v; r.chk_en = 1; r.ev = 1; r.es = es; r.ew = ew;
        return r;
    endfunction

    function automatic vec_t ex0(input vec_t v);
        vec_t r;
        r = v; r.chk_en = 1; r.ev = 0;
        return r;
    endfunction

    task automatic apply(input vec_t v);
        reset    = (v.rst != 0);
        in_valid = (v.iv != 0);
        in_addr  = AW'(v.ia);
        in_first = (v.fst != 0);
        in_data  = v.id;
        out_req  = (v.oq != 0);
        out_addr = AW'(v.oa);
        out_relu = (v.relu != 0);
        out_clr  = (v.clr != 0);
    endtask

    vec_t tbl [31];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] relu_in, relu_out;
        relu_in  = lanes8(-4, 9, -1, 3, 0, -32768, 32767, 2);
        relu_out = lanes8(0, 9, 0, 3, 0, 0, 32767, 2);

        // Output expectations in each row refer to the outputs seen after that row's clock edge.
        tbl[0]  = ex0(acc_r(3, 1, rep(5)));
        tbl[1]  = ex0(acc_r(3, 0, rep(7)));
        tbl[2]  = ex0(idle_r());
        tbl[3]  = ex0(drn_r(3, 0, 0));
        tbl[4]  = ex(idle_r(), rep(12), rep(12));
        tbl[5]  = ex0(acc_r(4, 1, rep(100)));
        tbl[6]  = ex0(drn_r(4, 0, 0));
        tbl[7]  = ex(idle_r(), rep(100), rep(100));
        tbl[8]  = ex0(acc_r(5, 1, lanes8(32000, -32000, 0, 0, 0, 0, 0, 0)));
        tbl[9]  = ex0(acc_r(5, 0, lanes8(1000, -1000, 0, 0, 0, 0, 0, 0)));
        tbl[10] = ex0(drn_r(5, 0, 0));
        tbl[11] = ex(idle_r(), lanes8(32767, -32768, 0, 0, 0, 0, 0, 0),
                               lanes8(-32536, 32536, 0, 0, 0, 0, 0, 0));
        tbl[12] = ex0(acc_r(10, 1, relu_in));
        tbl[13] = ex0(drn_r(10, 1, 1));
        tbl[14] = ex(drn_r(10, 0, 0), relu_out, relu_out);
        tbl[15] = ex(idle_r(), rep(0), rep(0));
        tbl[16] = ex0(acc_r(0, 1, rep(1)));
        tbl[17] = ex0(acc_r(0, 0, rep(1)));
        tbl[18] = ex0(mk(1, 1, 0, 0, rep(1), 1, 10, 0, 0));
        tbl[19] = ex(acc_r(0, 0, rep(1)), rep(0), rep(0));
        tbl[20] = ex0(acc_r(0, 0, rep(1)));
        tbl[21] = ex0(drn_r(0, 0, 0));
        tbl[22] = ex(idle_r(), rep(4), rep(4));
        tbl[23] = ex0(acc_r(20, 1, rep(77)));
        tbl[24] = ex0(idle_r());
        tbl[25] = ex0(drn_r(20, 0, 1));
        tbl[26] = ex0(mk(0, 0, 0, 0, '0, 0, 0, 0, 0));
        tbl[27] = ex0(mk(0, 0, 0, 0, '0, 0, 0, 0, 0));
        tbl[28] = ex0(drn_r(20, 0, 0));
        tbl[29] = ex(idle_r(), rep(77), rep(77));
        tbl[30] = ex0(idle_r());

        // Power-on reset.
        apply(mk(0, 0, 0, 0, '0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) cycle();

        for (int i = 0; i < 31; i++) begin
            apply(tbl[i]);
            if (i == 18) begin
                #1;
                chk("tbl_in_ready_blocked", W'(rdy_s), '0);
            end
            cycle();
            if (tbl[i].chk_en != 0) begin
                chk($sformatf("tbl%0d_valid", i), W'(ov_s), W'(tbl[i].ev));
                if (tbl[i].ev != 0) begin
                    chk($sformatf("tbl%0d_sat", i), od_s, tbl[i].es);
                    chk($sformatf("tbl%0d_wrap", i), od_w, tbl[i].ew);
                end
            end
        end

        // Random stress against the model over a small address window to provoke hazards.
        for (int n = 0; n < 10000; n++) begin
            logic [AW-1:0] a;
            logic [W-1:0] d;
            reset = ($urandom_range(0, 499) != 0);
            a = AW'($urandom_range(0, 15));
            out_addr = a;
            out_req  = reset && ($urandom_range(0, 3) == 0) && known[a];
            out_relu = $urandom_range(0, 1) == 1;
            out_clr  = $urandom_range(0, 5) == 0;
            in_valid = reset && ($urandom_range(0, 9) < 6);
            in_addr  = AW'($urandom_range(0, 15));
            in_first = !known[in_addr] || ($urandom_range(0, 7) == 0);
            d = '0;
            for (int l = 0; l < 8; l++) begin
                if ($urandom_range(0, 1) == 1) d[l*16 +: 16] = 16'($urandom_range(0, 100) - 50);
                else d[l*16 +: 16] = 16'($urandom);
            end
            in_data = d;
            cycle();
        end

        apply(idle_r());
        for (int i = 0; i < 3; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_acc_buffer.md
# psum_acc_buffer

Parametrised read-modify-write accumulation buffer for partial sums leaving the systolic array, replacing the fixed 32-bit accumulation SRAM path inside the core. Each incoming `col`-lane psum vector is added lane-wise into a 1R1W bank at a given address, with an optional overwrite, saturation and back-to-back hazard forwarding. A drain port reads vectors back, with optional per-lane ReLU and clear-on-read, for the SFP/output path.

## Interface
- `col`, 8, number of psum lanes per vector
- `psum_bw`, 16, signed width of each lane
- `depth`, 2048, vectors in the bank; `aw = $clog2(depth)`
- `sat`, 1, 1 = signed saturating add, 0 = two's-complement wrap

- `clk` input 1: single clock, all state on rising edge
- `reset` input 1: synchronous, active-low (0 = reset)
- `in_valid` input 1: accumulate request
- `in_ready` output 1: request accepted when `in_valid && in_ready`
- `in_addr` input aw: target vector address
- `in_first` input 1: 1 = write `in_data` as-is (overwrite), 0 = accumulate
- `in_data` input psum_bw*col: lane i in bits [psum_bw*i +: psum_bw]
- `out_req` input 1: drain read request, always accepted
- `out_addr` input aw: drain address
- `out_relu` input 1: clamp negative lanes to 0 on output
- `out_clr` input 1: zero the address after reading it
- `out_valid` output 1: `out_data` valid this cycle
- `out_data` output psum_bw*col: drained vector
- `busy` output 1: any pipeline stage occupied

## Operation
- Internal 1R1W bank, `depth` x `psum_bw*col`. Synchronous read: data returns 1 cycle after the address. Read-during-write to the same address returns **old** data. Contents are not cleared by reset.
- Accumulate pipeline:
  - S0 (accept): issue read of `in_addr`; latch addr, first and data into S1.
  - S1: compute `sum = first ? data : rd + data` per lane; issue the write.
- Add rules:
  - Widths are `psum_bw` signed; no carry-out lane.
  - With `sat=1`: positive overflow → 2^(psum_bw-1)-1, negative overflow → -2^(psum_bw-1).
  - With `sat=0`: result wraps.
- Forwarding:
  - If the S1 write address equals the address the S1 read returns for, with that read issued in the cycle the previous beat wrote, substitute the previous beat's written value for `rd`.
  - Applies to back-to-back accumulates and to a drain read issued the cycle after an accumulate to the same address.
- Arbitration:
  - `in_ready = reset && !out_req`; drain has priority over accumulate for the read port.
  - `in_valid` held while `in_ready=0` is neither lost nor duplicated.
- Drain:
  - `out_req` in cycle t issues the read; the data is registered into `out_data` at the end of t+1.
  - ReLU is applied per lane when `out_relu` was sampled 1 with the request.
- Clear-on-read: if `out_clr`, write zero to `out_addr` in t+1. The write port is free in t+1 because no accumulate was accepted at t.
- `busy` is high when S1 or either drain stage is valid.

## Timing
- Reset, synchronous with `reset=0` at the clock edge:
  - `out_valid=0`, `out_data=0`, `busy=0`, `in_ready=0` while `reset=0`.
  - All pipeline valid bits cleared; an in-flight write is dropped.
- Accumulate: accepted at t → bank updated at the edge ending t+1 → a read issued at t+2 sees the new value directly.
- Sustained throughput is 1 accumulate per cycle, including repeated same address (forwarding).
- Drain latency is 2: `out_req` at t → `out_valid=1` during t+2, for exactly 1 cycle per request. Back-to-back requests give back-to-back valid cycles.
- Out-of-range address cannot occur (`depth` is a power of 2); a non-power-of-2 `depth` is unsupported.
- Reset asserted mid-drain: the pending `out_valid` is suppressed.

## Structure
- Shared package `acc_pkg`: lane-slice helper function, saturating add function `sat_add(a,b)`, ReLU function, and localparam `aw`.
- One sub-module `acc_bank_1r1w`: the synchronous 1R1W memory (behavioural, later swapped for a macro). Pipeline, forwarding and arbitration live in `psum_acc_buffer`.

## Test plan
- Accumulate:
  - Stimulus: `in_first=1` data all lanes 5 @addr 3, then `in_first=0` data all lanes 7 @addr 3 on consecutive cycles; `out_req` @3 two cycles later.
  - Response: `out_valid` 2 cycles after the request, every lane 12 (checks forwarding).
- Saturation:
  - Stimulus: `sat=1`, lane 0 = 32000 then +1000.
  - Response: lane 0 drains 32767.
  - Same sequence with `sat=0`: lane 0 drains -32536.
- ReLU and clear:
  - Stimulus: write lanes {-4, 9, ...} @addr 10; drain with `out_relu=1, out_clr=1`, then drain @10 again.
  - Response: first drain {0, 9, ...}; second drain all zero.
- Arbitration:
  - Stimulus: hold `in_valid` with 4 beats of +1 @addr 0 while `out_req` pulses in beat 2.
  - Response: `in_ready=0` that cycle; final drain value 4, no lost or duplicated beat.
- Reset:
  - Stimulus: assert `reset=0` one cycle after an `out_req`.
  - Response: no `out_valid`, `busy=0`, `in_ready=0`; bank contents at untouched addresses unchanged after release.
- Random stress: 10k random accumulates/drains against a scoreboard model; every drained vector matches.
